// File: rtl/frogger_pkg.sv
// rtl/frogger_pkg.sv - shared game-flow state encoding and bus widths
package frogger_pkg;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    HOLD      = 2'd1,
    GAME_OVER = 2'd2
  } game_state_t;

  localparam int LEVEL_W = 4;
  localparam int LIVES_W = 2;
  localparam int SPEED_W = 3;

endpackage

// File: rtl/edge_pulse.sv
// rtl/edge_pulse.sv - registers a level flag and flags its rising edge
module edge_pulse (
  input  logic clk,
  input  logic reset_n,
  input  logic flag,
  output logic pulse
);

  logic sample_q;
  logic prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sample_q <= flag;
      prev_q   <= sample_q;
    end
  end

  assign pulse = sample_q & ~prev_q;

endmodule

// File: rtl/game_flow_controller.sv
// rtl/game_flow_controller.sv - level/lives/respawn sequencer with post-event frame hold
// FROGGER_LIVES_EN: track lives and allow GAME_OVER; otherwise lives is constant.
module game_flow_controller
  import frogger_pkg::*;
#(
  parameter int MAX_LEVEL   = 9,
  parameter int START_LIVES = 3,
  parameter int HOLD_FRAMES = 30
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_tick,
  input  logic               win_collision,
  input  logic               death_collision,
  input  logic               restart_req,
  output logic [LEVEL_W-1:0] level,
  output logic [LIVES_W-1:0] lives,
  output logic [SPEED_W-1:0] car_speed,
  output logic               frog_reset,
  output logic               game_over
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  logic win_ev, death_ev, restart_ev;

  edge_pulse u_win     (.clk(clk), .reset_n(reset_n), .flag(win_collision),   .pulse(win_ev));
  edge_pulse u_death   (.clk(clk), .reset_n(reset_n), .flag(death_collision), .pulse(death_ev));
  edge_pulse u_restart (.clk(clk), .reset_n(reset_n), .flag(restart_req),     .pulse(restart_ev));

  game_state_t        state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               frog_reset_q, frog_reset_d;
  logic               game_over_q, game_over_d;
  logic               death_fatal;

`ifdef FROGGER_LIVES_EN
  logic [LIVES_W-1:0] lives_q, lives_d;

  assign death_fatal = (lives_q == LIVES_W'(1));

  // A simultaneous win shadows the death, so lives only drop on a lone death.
  always_comb begin
    lives_d = lives_q;
    if (restart_ev)
      lives_d = LIVES_W'(START_LIVES);
    else if (state_q == PLAY && !win_ev && death_ev)
      lives_d = lives_q - LIVES_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lives_q <= LIVES_W'(START_LIVES);
    else          lives_q <= lives_d;
  end

  assign lives = lives_q;
`else
  assign death_fatal = 1'b0;
  assign lives       = LIVES_W'(START_LIVES);
`endif

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    hold_d       = hold_q;
    frog_reset_d = 1'b0;
    if (restart_ev) begin
      level_d      = '0;
      hold_d       = '0;
      frog_reset_d = 1'b1;
      state_d      = HOLD;
    end else begin
      case (state_q)
        PLAY: begin
          if (win_ev) begin
            level_d      = (level_q == LEVEL_W'(MAX_LEVEL)) ? '0 : level_q + LEVEL_W'(1);
            hold_d       = '0;
            frog_reset_d = 1'b1;
            state_d      = HOLD;
          end else if (death_ev) begin
            if (death_fatal) begin
              state_d = GAME_OVER;
            end else begin
              hold_d       = '0;
              frog_reset_d = 1'b1;
              state_d      = HOLD;
            end
          end
        end
        HOLD: begin
          if (frame_tick) begin
            if (hold_q == HOLD_W'(HOLD_FRAMES - 1)) begin
              hold_d  = '0;
              state_d = PLAY;
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
        end
        GAME_OVER: ;
        default: state_d = PLAY;
      endcase
    end
    game_over_d = (state_d == GAME_OVER);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= PLAY;
      level_q      <= '0;
      hold_q       <= '0;
      frog_reset_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      hold_q       <= hold_d;
      frog_reset_q <= frog_reset_d;
      game_over_q  <= game_over_d;
    end
  end

  assign level      = level_q;
  assign frog_reset = frog_reset_q;
  assign game_over  = game_over_q;
  assign car_speed  = level_q[3:1] + SPEED_W'(1);

endmodule

// File: tb/tb_game_flow_controller.sv
// tb/tb_game_flow_controller.sv - directed scoreboard bench for game_flow_controller
module tb_game_flow_controller;
  import frogger_pkg::*;

  localparam int MAX_LEVEL   = 9;
  localparam int START_LIVES = 3;
  localparam int HOLD_FRAMES = 30;
`ifdef FROGGER_LIVES_EN
  localparam bit LIVES_EN = 1'b1;
`else
  localparam bit LIVES_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               frame_tick = 1'b0;
  logic               win_collision = 1'b0;
  logic               death_collision = 1'b0;
  logic               restart_req = 1'b0;
  logic [LEVEL_W-1:0] level;
  logic [LIVES_W-1:0] lives;
  logic [SPEED_W-1:0] car_speed;
  logic               frog_reset;
  logic               game_over;

  typedef struct {
    string tag;
    int    level;
    int    lives;
    int    frog;
    int    go;
    int    speed;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   frog_seen = 0;
  int   frog_exp = 0;
  int   m_level, m_lives, m_hold, m_st;

  game_flow_controller #(
    .MAX_LEVEL  (MAX_LEVEL),
    .START_LIVES(START_LIVES),
    .HOLD_FRAMES(HOLD_FRAMES)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .frame_tick     (frame_tick),
    .win_collision  (win_collision),
    .death_collision(death_collision),
    .restart_req    (restart_req),
    .level          (level),
    .lives          (lives),
    .car_speed      (car_speed),
    .frog_reset     (frog_reset),
    .game_over      (game_over)
  );

  always #20 clk = ~clk;

  always @(negedge clk) if (frog_reset === 1'b1) frog_seen++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model state: 0 = play, 1 = hold, 2 = game over.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      if (m_st == 1) begin
        m_hold++;
        if (m_hold == HOLD_FRAMES) m_st = 0;
      end
      tick();
    end
  endtask

  task automatic do_event(input string tag, input logic w, input logic d, input logic r,
                          input bit entry_tick, input int extra);
    exp_t e;
    e.frog = 0;
    if (r) begin
      m_level = 0; m_lives = START_LIVES; m_st = 1; m_hold = 0; e.frog = 1;
    end else if (m_st == 0 && w) begin
      m_level = (m_level == MAX_LEVEL) ? 0 : m_level + 1;
      m_st = 1; m_hold = 0; e.frog = 1;
    end else if (m_st == 0 && d) begin
      if (LIVES_EN && m_lives == 1) begin
        m_lives = 0; m_st = 2;
      end else begin
        if (LIVES_EN) m_lives--;
        m_st = 1; m_hold = 0; e.frog = 1;
      end
    end
    frog_exp += e.frog;
    e.tag   = tag;
    e.level = m_level;
    e.lives = m_lives;
    e.go    = (m_st == 2) ? 1 : 0;
    e.speed = (m_level >> 1) + 1;
    exp_q.push_back(e);

    win_collision   = w;
    death_collision = d;
    restart_req     = r;
    tick();
    frame_tick = entry_tick;
    tick();
    frame_tick = 1'b0;

    e = exp_q.pop_front();
    chk({e.tag, "_level"}, 32'(level), e.level);
    chk({e.tag, "_lives"}, 32'(lives), e.lives);
    chk({e.tag, "_frog"}, 32'(frog_reset), e.frog);
    chk({e.tag, "_game_over"}, 32'(game_over), e.go);
    chk({e.tag, "_speed"}, 32'(car_speed), e.speed);

    repeat (extra) tick();
    win_collision   = 1'b0;
    death_collision = 1'b0;
    restart_req     = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    m_level = 0; m_lives = START_LIVES; m_hold = 0; m_st = 0;
    tick();
    tick();
    chk("reset_level", 32'(level), 0);
    chk("reset_lives", 32'(lives), START_LIVES);
    chk("reset_speed", 32'(car_speed), 1);
    chk("reset_frog", 32'(frog_reset), 0);
    chk("reset_game_over", 32'(game_over), 0);
    reset_n = 1'b1;
    tick();

    // Held win with a frame_tick on the entry cycle, which must not count.
    do_event("win_first", 1'b1, 1'b0, 1'b0, 1'b1, 3);
    frames(HOLD_FRAMES - 1);
    do_event("death_in_hold", 1'b0, 1'b1, 1'b0, 1'b0, 0);
    frames(1);
    do_event("win_after_hold", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    frames(HOLD_FRAMES);
    for (int i = 0; i < 7; i++) begin
      do_event($sformatf("win_climb%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 0);
      frames(HOLD_FRAMES);
    end
    do_event("win_wrap", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    frames(HOLD_FRAMES);
    do_event("win_death_same", 1'b1, 1'b1, 1'b0, 1'b0, 0);
    frames(HOLD_FRAMES);

    do_event("restart_play", 1'b0, 1'b0, 1'b1, 1'b0, 0);
    frames(20);
    do_event("restart_hold", 1'b0, 1'b0, 1'b1, 1'b0, 0);
    frames(HOLD_FRAMES - 1);
    do_event("win_late_hold", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    frames(1);
    do_event("win_after_reload", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    frames(HOLD_FRAMES);

`ifdef FROGGER_LIVES_EN
    for (int i = 0; i < 3; i++) begin
      do_event($sformatf("death%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 0);
      frames(HOLD_FRAMES);
    end
    do_event("win_game_over", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    do_event("death_game_over", 1'b0, 1'b1, 1'b0, 1'b0, 0);
    do_event("restart_game_over", 1'b0, 1'b0, 1'b1, 1'b0, 0);
    frames(10);
    do_event("death_hold_a", 1'b0, 1'b1, 1'b0, 1'b0, 0);
    frames(HOLD_FRAMES - 11);
    do_event("death_hold_b", 1'b0, 1'b1, 1'b0, 1'b0, 0);
    frames(1);
    do_event("death_after_restart", 1'b0, 1'b1, 1'b0, 1'b0, 0);
    frames(HOLD_FRAMES);
`else
    for (int i = 0; i < 5; i++) begin
      do_event($sformatf("death%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 0);
      frames(HOLD_FRAMES);
    end
`endif

    do_event("win_pre_reset", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("frog_pulse_count", 32'(frog_seen), frog_exp);

    @(negedge clk);
    #5;
    reset_n = 1'b0;
    #1;
    chk("async_level", 32'(level), 0);
    chk("async_lives", 32'(lives), START_LIVES);
    chk("async_speed", 32'(car_speed), 1);
    chk("async_game_over", 32'(game_over), 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
# game_flow_controller

Game-flow sequencer sitting directly downstream of the collision detector and upstream of the frog, car and seven-segment blocks. Converts level-type win/death collision flags into single events; tracks level, lives and game-over; and issues the one-cycle frog respawn pulse. Applies a frame-counted hold after every event so that overlapping collisions and switch chatter cannot double-count. Drives level to the digit decoder and a speed code to the car movers.

## Interface
Parameters:
- MAX_LEVEL, 9: highest level value; the next win wraps level to 0.
- START_LIVES, 3: lives loaded at reset and on restart (1..3).
- HOLD_FRAMES, 30: frame_tick pulses spent in a hold state after an event (≥1).

Ports (one clock; reset is asynchronous and active-low):
- clk, in, 1: system clock (25 MHz pixel clock).
- reset_n, in, 1: asynchronous active-low reset.
- frame_tick, in, 1: one-cycle pulse per video frame (start of vsync).
- win_collision, in, 1: level flag; frog overlaps the goal row.
- death_collision, in, 1: level flag; frog overlaps a car.
- restart_req, in, 1: level flag; all four switches are held.
- level, out, 4: current level, 0..MAX_LEVEL.
- lives, out, 2: remaining lives.
- car_speed, out, 3: level[3:1] + 1; range 1..5 at MAX_LEVEL = 9.
- frog_reset, out, 1: one-cycle respawn pulse.
- game_over, out, 1: high while in GAME_OVER.

## Operation
- All three flag inputs are registered; event = current sample high AND previous sample low.
- States:
  - PLAY
  - HOLD: respawn hold, entered after a win, a non-fatal death or a restart.
  - GAME_OVER
- Event priority: restart > win > death. A win and a death in the same cycle count as a win only.
- Restart (any state):
  - level ← 0, lives ← START_LIVES.
  - Pulse frog_reset; go to HOLD.
- PLAY, win event:
  - level ← level+1, or 0 if level == MAX_LEVEL.
  - Pulse frog_reset; go to HOLD.
- PLAY, death event, lives > 1: lives ← lives−1; pulse frog_reset; go to HOLD.
- PLAY, death event, lives == 1: lives ← 0; go to GAME_OVER. No frog_reset pulse; the frog freezes where it is.
- HOLD:
  - Win and death events are ignored.
  - Counter clears on entry and increments on each frame_tick.
  - On the frame_tick that brings the count to HOLD_FRAMES, go to PLAY.
- GAME_OVER: only restart is honoured.
- The edge registers update in every state. A flag already high when HOLD ends does not generate an event.
- car_speed is derived from the registered level.

## Timing
- Reset values:
  - level = 0, lives = START_LIVES, car_speed = 1.
  - frog_reset = 0, game_over = 0.
  - State = PLAY, hold counter = 0, edge registers = 0.
- Event latency: an input first sampled high at clock edge k yields the event at edge k+1. At that edge, level, lives, frog_reset, game_over and the state all update together.
- frog_reset is high for exactly one cycle per qualifying event.
- game_over is registered and equals (state == GAME_OVER).
- Hold duration is exactly HOLD_FRAMES frame_tick pulses. A frame_tick in the entry cycle is not counted.
- A restart during HOLD reloads the counter to 0 and pulses frog_reset again.
- reset_n asserted mid-operation forces all reset values immediately, without waiting for a clock edge.

## Configuration
- FROGGER_LIVES_EN defined: lives are tracked as described, and GAME_OVER is reachable.
- FROGGER_LIVES_EN undefined:
  - The lives register is removed; lives is tied to START_LIVES.
  - Every death behaves as a non-fatal death (frog_reset, then HOLD).
  - GAME_OVER is unreachable and game_over is tied to 0.

## Structure
- The shared package frogger_pkg holds:
  - the state encoding (PLAY, HOLD, GAME_OVER);
  - LEVEL_W = 4, LIVES_W = 2, SPEED_W = 3.
- One sub-module, edge_pulse: a 1-bit register plus rising-edge output, instantiated once per flag input.

## Test plan
- Reset, then win_collision high for 5 cycles: level 0→1 one cycle after the first sample, one frog_reset pulse, car_speed stays 1. After 30 frame_ticks, state returns to PLAY.
- Win events at level 9 → level 0, car_speed 1. From level 3, a win → level 4, car_speed 3.
- Three deaths, each separated by a full hold: lives 3→2→1→0. The third death raises game_over with no frog_reset. Further win/death pulses change nothing.
- win_collision and death_collision rising in the same cycle: level increments, lives unchanged.
- In GAME_OVER, assert restart_req: level 0, lives 3, game_over 0, frog_reset pulses once. Death pulses during the next 29 frame_ticks are ignored.
- Build without FROGGER_LIVES_EN and apply 5 deaths: lives stays 3, game_over stays 0, five frog_reset pulses.
